// File: rtl/pad_bus_ctrl.sv
// Half-duplex pad-bank controller: round-robin write/read sharing with drive/hold/turnaround sequencing of pad_oen.
// Optional macro PAD_BUS_CTRL_SYNC_EN adds a 2-flop pad_di synchronizer and stretches SAMPLE to 3 cycles.
module pad_bus_ctrl #(
    parameter int WIDTH    = 8,
    parameter int HOLD_CYC = 1,
    parameter int TURN_CYC = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_valid,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_ready,
    input  logic             rd_req,
    output logic             rd_ready,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic [WIDTH-1:0] pad_do,
    output logic [WIDTH-1:0] pad_oen,
    input  logic [WIDTH-1:0] pad_di,
    output logic             busy
);

`ifdef PAD_BUS_CTRL_SYNC_EN
    localparam int SAMPLE_CYC = 3;
`else
    localparam int SAMPLE_CYC = 1;
`endif

    localparam int CNT_MAX_HT = (HOLD_CYC > TURN_CYC) ? HOLD_CYC : TURN_CYC;
    localparam int CNT_MAX    = (CNT_MAX_HT > SAMPLE_CYC - 1) ? CNT_MAX_HT : SAMPLE_CYC - 1;
    localparam int CNT_W      = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

    // Counter load values: state lasts (load + 1) cycles, counting down to zero.
    localparam logic [CNT_W-1:0] HOLD_LD = (HOLD_CYC > 0) ? CNT_W'(HOLD_CYC - 1) : '0;
    localparam logic [CNT_W-1:0] TURN_LD = (TURN_CYC > 0) ? CNT_W'(TURN_CYC - 1) : '0;
    localparam logic [CNT_W-1:0] SAMP_LD = CNT_W'(SAMPLE_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_HOLD,
        S_TURN,
        S_SAMPLE
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_next;
    logic               r_last_wr;
    logic [WIDTH-1:0]   r_pad_do;
    logic [WIDTH-1:0]   r_rd_data;
    logic               r_rd_valid;
    logic               w_wr_ready;
    logic               w_rd_ready;
    logic [WIDTH-1:0]   w_di_cap;

`ifdef PAD_BUS_CTRL_SYNC_EN
    logic [WIDTH-1:0]   r_sync1;
    logic [WIDTH-1:0]   r_sync2;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= pad_di;
            r_sync2 <= r_sync1;
        end
    end

    assign w_di_cap = r_sync2;
`else
    assign w_di_cap = pad_di;
`endif

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_wr_ready   = 1'b0;
        w_rd_ready   = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Ties go to whichever side was not granted last; the other side waits.
                w_wr_ready = wr_valid && (!rd_req || !r_last_wr);
                w_rd_ready = rd_req && (!wr_valid || r_last_wr);
                if (w_wr_ready) begin
                    w_state_next = S_DRIVE;
                end else if (w_rd_ready) begin
                    w_state_next = S_SAMPLE;
                    w_cnt_next   = SAMP_LD;
                end
            end
            S_DRIVE: begin
                if (HOLD_CYC > 0) begin
                    w_state_next = S_HOLD;
                    w_cnt_next   = HOLD_LD;
                end else if (TURN_CYC > 0) begin
                    w_state_next = S_TURN;
                    w_cnt_next   = TURN_LD;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_HOLD: begin
                if (r_cnt == '0) begin
                    if (TURN_CYC > 0) begin
                        w_state_next = S_TURN;
                        w_cnt_next   = TURN_LD;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            S_TURN, S_SAMPLE: begin
                if (r_cnt == '0) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_last_wr  <= 1'b0;
            r_pad_do   <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_rd_valid <= 1'b0;
            if (w_wr_ready) begin
                r_pad_do  <= wr_data;
                r_last_wr <= 1'b1;
            end
            if (w_rd_ready) begin
                r_last_wr <= 1'b0;
            end
            // Capture on the edge that leaves SAMPLE; rd_valid pulses the cycle after.
            if (r_state == S_SAMPLE && r_cnt == '0) begin
                r_rd_data  <= w_di_cap;
                r_rd_valid <= 1'b1;
            end
        end
    end

    assign wr_ready = w_wr_ready;
    assign rd_ready = w_rd_ready;
    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign pad_do   = r_pad_do;
    assign pad_oen  = {WIDTH{(r_state == S_DRIVE) || (r_state == S_HOLD)}};
    assign busy     = (r_state != S_IDLE);

endmodule
